// File: rtl/aes_key_sched_ctrl.sv
// AES-128 key expansion sequencer: latches a cipher key on start and streams
// round keys 0..NR over a valid/ready handshake, one key per accepted cycle.
module aes_key_sched_ctrl #(
  parameter int NR = 10
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         start,
  input  logic [127:0] key_in,
  output logic         rk_valid,
  input  logic         rk_ready,
  output logic [127:0] rk_data,
  output logic [3:0]   rk_round,
  output logic         busy,
  output logic         done
);

  typedef enum logic [1:0] {IDLE, EMIT, DONE} state_t;

  localparam logic [3:0] LAST = 4'(NR);

  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]};
  endfunction

  function automatic logic [31:0] rcon(input logic [3:0] idx);
    case (idx)
      4'd1:    return 32'h01000000;
      4'd2:    return 32'h02000000;
      4'd3:    return 32'h04000000;
      4'd4:    return 32'h08000000;
      4'd5:    return 32'h10000000;
      4'd6:    return 32'h20000000;
      4'd7:    return 32'h40000000;
      4'd8:    return 32'h80000000;
      4'd9:    return 32'h1b000000;
      4'd10:   return 32'h36000000;
      default: return 32'h00000000;
    endcase
  endfunction

  state_t       state, state_nxt;
  logic         load, advance;
  logic [3:0]   round_inc;
  logic [31:0]  t, w0n, w1n, w2n, w3n;
  logic [127:0] next_key;

  // Single-cycle key expansion step from the key currently presented
  always_comb begin
    round_inc = rk_round + 4'd1;
    t         = sub_word({rk_data[23:0], rk_data[31:24]}) ^ rcon(round_inc);
    w0n       = rk_data[127:96] ^ t;
    w1n       = rk_data[95:64]  ^ w0n;
    w2n       = rk_data[63:32]  ^ w1n;
    w3n       = rk_data[31:0]   ^ w2n;
    next_key  = {w0n, w1n, w2n, w3n};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    advance   = 1'b0;
    case (state)
      IDLE: if (start) begin
        load      = 1'b1;
        state_nxt = EMIT;
      end
      EMIT: if (rk_ready) begin
        if (rk_round == LAST) state_nxt = DONE;
        else                  advance   = 1'b1;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rk_data  <= '0;
      rk_round <= '0;
    end else if (load) begin
      rk_data  <= key_in;
      rk_round <= '0;
    end else if (advance) begin
      rk_data  <= next_key;
      rk_round <= round_inc;
    end
  end

  // Status decoded from the state register so reset clears it immediately
  assign rk_valid = (state == EMIT);
  assign busy     = (state == EMIT);
  assign done     = (state == DONE);

endmodule
